// File: rtl/cmult_pkg.sv
// Shared definitions for the shared complex multiplier: width helpers, build-time
// operand widths and the stage-1 operand bundle.
package cmult_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int id_width(input int num_req);
    return (clog2(num_req) > 1) ? clog2(num_req) : 1;
  endfunction

  function automatic int mult_width(input int dina_width, input int dinb_width);
    return dina_width + dinb_width + 1;
  endfunction

  // Build configuration; the top-level parameters default to these and must match them.
  localparam int CMULT_NUM_REQ    = 4;
  localparam int CMULT_DINA_WIDTH = 16;
  localparam int CMULT_DINB_WIDTH = 16;
  localparam int CMULT_ID_WIDTH   = id_width(CMULT_NUM_REQ);

  typedef struct packed {
    logic signed [CMULT_DINA_WIDTH-1:0] a_i;
    logic signed [CMULT_DINA_WIDTH-1:0] a_q;
    logic signed [CMULT_DINB_WIDTH-1:0] b_i;
    logic signed [CMULT_DINB_WIDTH-1:0] b_q;
    logic [CMULT_ID_WIDTH-1:0]          id;
  } s1_bundle_t;

endpackage

// File: rtl/cmult_rr_arb.sv
// Round-robin arbiter: searches req_valid starting at ptr, grants one channel
// when en is high, and advances ptr past the granted channel.
module cmult_rr_arb
  import cmult_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic                en,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic [ID_WIDTH-1:0] ptr;
  logic                found;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int cand;
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = ID_WIDTH'(cand);
      end
    end
    grant = (found && en && !rst) ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
    end
  end

endmodule

// File: rtl/complex_mult.sv
// Combinational full-precision complex multiply using three real multipliers
// (k1 = b_i*(a_i+a_q), k2 = a_i*(b_q-b_i), k3 = a_q*(b_i+b_q)).
module complex_mult
  import cmult_pkg::*;
#(
  parameter  int DINA_WIDTH = 16,
  parameter  int DINB_WIDTH = 16,
  localparam int MULT_WIDTH = mult_width(DINA_WIDTH, DINB_WIDTH)
) (
  input  logic signed [DINA_WIDTH-1:0] a_i,
  input  logic signed [DINA_WIDTH-1:0] a_q,
  input  logic signed [DINB_WIDTH-1:0] b_i,
  input  logic signed [DINB_WIDTH-1:0] b_q,
  output logic signed [MULT_WIDTH-1:0] p_i,
  output logic signed [MULT_WIDTH-1:0] p_q
);

  logic signed [MULT_WIDTH-1:0] a_i_x, a_q_x, b_i_x, b_q_x;
  logic signed [MULT_WIDTH-1:0] sum_a, diff_b, sum_b;
  logic signed [MULT_WIDTH-1:0] k1, k2, k3;

  assign a_i_x = {{(MULT_WIDTH-DINA_WIDTH){a_i[DINA_WIDTH-1]}}, a_i};
  assign a_q_x = {{(MULT_WIDTH-DINA_WIDTH){a_q[DINA_WIDTH-1]}}, a_q};
  assign b_i_x = {{(MULT_WIDTH-DINB_WIDTH){b_i[DINB_WIDTH-1]}}, b_i};
  assign b_q_x = {{(MULT_WIDTH-DINB_WIDTH){b_q[DINB_WIDTH-1]}}, b_q};

  // Intermediates may exceed MULT_WIDTH only transiently; the final sums always fit,
  // so modulo-2^MULT_WIDTH arithmetic yields the exact product.
  assign sum_a  = a_i_x + a_q_x;
  assign diff_b = b_q_x - b_i_x;
  assign sum_b  = b_i_x + b_q_x;

  assign k1 = b_i_x * sum_a;
  assign k2 = a_i_x * diff_b;
  assign k3 = a_q_x * sum_b;

  assign p_i = k1 - k3;
  assign p_q = k1 + k2;

endmodule

// File: rtl/cmult_share_arb.sv
// One complex multiplier shared by NUM_REQ requesters through a round-robin arbiter
// and a 2-stage stall-able pipeline. Define CMULT_SHARE_STAT_EN to add stat_txn_cnt.
module cmult_share_arb
  import cmult_pkg::*;
#(
  parameter  int NUM_REQ    = CMULT_NUM_REQ,
  parameter  int DINA_WIDTH = CMULT_DINA_WIDTH,
  parameter  int DINB_WIDTH = CMULT_DINB_WIDTH,
  localparam int MULT_WIDTH = mult_width(DINA_WIDTH, DINB_WIDTH),
  localparam int ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DINA_WIDTH-1:0] req_dina_i,
  input  logic [NUM_REQ*DINA_WIDTH-1:0] req_dina_q,
  input  logic [NUM_REQ*DINB_WIDTH-1:0] req_dinb_i,
  input  logic [NUM_REQ*DINB_WIDTH-1:0] req_dinb_q,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic signed [MULT_WIDTH-1:0]  out_i,
  output logic signed [MULT_WIDTH-1:0]  out_q
`ifdef CMULT_SHARE_STAT_EN
  ,
  output logic [31:0]                   stat_txn_cnt
`endif
);

  logic                         en1, en2;
  logic                         s1_valid;
  logic [NUM_REQ-1:0]           grant;
  logic [ID_WIDTH-1:0]          grant_idx;
  s1_bundle_t                   s1, s1_next;
  logic signed [MULT_WIDTH-1:0] prod_i, prod_q;

  assign en2       = !out_valid || out_ready;
  assign en1       = !s1_valid || en2;
  assign req_ready = grant;

  cmult_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .en        (en1),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    s1_next.a_i = req_dina_i[grant_idx*DINA_WIDTH +: DINA_WIDTH];
    s1_next.a_q = req_dina_q[grant_idx*DINA_WIDTH +: DINA_WIDTH];
    s1_next.b_i = req_dinb_i[grant_idx*DINB_WIDTH +: DINB_WIDTH];
    s1_next.b_q = req_dinb_q[grant_idx*DINB_WIDTH +: DINB_WIDTH];
    s1_next.id  = grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (en1) begin
      s1_valid <= |grant;
    end
  end

  // NOTE: the operand bundle is datapath-only and left unreset; s1_valid qualifies it.
  always_ff @(posedge clk) begin
    if (en1 && |grant) begin
      s1 <= s1_next;
    end
  end

  complex_mult #(
    .DINA_WIDTH (DINA_WIDTH),
    .DINB_WIDTH (DINB_WIDTH)
  ) u_mult (
    .a_i (s1.a_i),
    .a_q (s1.a_q),
    .b_i (s1.b_i),
    .b_q (s1.b_q),
    .p_i (prod_i),
    .p_q (prod_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_i     <= '0;
      out_q     <= '0;
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_id <= s1.id;
        out_i  <= prod_i;
        out_q  <= prod_q;
      end
    end
  end

`ifdef CMULT_SHARE_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_txn_cnt <= '0;
    end else if (out_valid && out_ready) begin
      stat_txn_cnt <= stat_txn_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmult_share_arb.sv
// Directed bench for cmult_share_arb (NUM_REQ=4, 16-bit operands) with an in-order
// scoreboard; stat_txn_cnt steps are compiled only with CMULT_SHARE_STAT_EN.
module tb_cmult_share_arb;
  localparam int NR = 4;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int MW = 33;
  localparam int IW = 2;

  typedef struct {
    logic [IW-1:0]      id;
    logic signed [63:0] i;
    logic signed [63:0] q;
  } want_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req_valid, req_ready;
  logic [NR*AW-1:0]     req_dina_i, req_dina_q;
  logic [NR*BW-1:0]     req_dinb_i, req_dinb_q;
  logic                 out_valid, out_ready;
  logic [IW-1:0]        out_id;
  logic signed [MW-1:0] out_i, out_q;
`ifdef CMULT_SHARE_STAT_EN
  logic [31:0]          stat_txn_cnt;
`endif

  int ai[NR], aq[NR], bi[NR], bq[NR];
  want_t sb[$];
  int errors = 0;
  int checks = 0;
  int seq = 0;
  int n_out = 0;
  int pat[3] = '{0, 2, 3};
  logic [IW-1:0]        snap_id;
  logic signed [MW-1:0] snap_i, snap_q;

  always #5 clk = ~clk;

  cmult_share_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dina_i (req_dina_i),
    .req_dina_q (req_dina_q),
    .req_dinb_i (req_dinb_i),
    .req_dinb_q (req_dinb_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_i      (out_i),
    .out_q      (out_q)
`ifdef CMULT_SHARE_STAT_EN
    ,
    .stat_txn_cnt (stat_txn_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(want));
    end
  endtask

  task automatic drive_data();
    for (int k = 0; k < NR; k++) begin
      req_dina_i[k*AW +: AW] = AW'(ai[k]);
      req_dina_q[k*AW +: AW] = AW'(aq[k]);
      req_dinb_i[k*BW +: BW] = BW'(bi[k]);
      req_dinb_q[k*BW +: BW] = BW'(bq[k]);
    end
  endtask

  task automatic refresh(input int g);
    seq++;
    ai[g] = (seq * 1237) % 65536 - 32768;
    aq[g] = (seq * 2741 + 11) % 65536 - 32768;
    bi[g] = (seq * 4099 + 7) % 65536 - 32768;
    bq[g] = (seq * 577 + 3) % 65536 - 32768;
  endtask

  function automatic logic signed [63:0] model_i(input int g);
    return longint'(ai[g]) * longint'(bi[g]) - longint'(aq[g]) * longint'(bq[g]);
  endfunction

  function automatic logic signed [63:0] model_q(input int g);
    return longint'(ai[g]) * longint'(bq[g]) + longint'(aq[g]) * longint'(bi[g]);
  endfunction

  // Samples both handshakes, advances one clock, then replaces the granted channel's data.
  task automatic cycle();
    int    g;
    want_t w;
    g = -1;
    for (int k = 0; k < NR; k++) if (req_valid[k] && req_ready[k]) g = k;
    if (!rst && g >= 0) begin
      w.id = IW'(g);
      w.i  = model_i(g);
      w.q  = model_q(g);
      sb.push_back(w);
    end
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        w = sb.pop_front();
        check("sb_id", 64'(out_id), 64'(w.id));
        check("sb_i", out_i, w.i);
        check("sb_q", out_q, w.q);
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      refresh(g);
      drive_data();
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && (sb.size() != 0 || out_valid); c++) begin
      #1;
      cycle();
    end
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("drain_idle", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    for (int k = 0; k < NR; k++) refresh(k);
    drive_data();
    #1;
    check("ready_in_rst", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    check("rst_out_i", out_i, 64'd0);
    check("rst_out_q", out_q, 64'd0);
    rst       = 1'b0;
    req_valid = '0;

    // Fairness: all channels valid, then channel 1 idle.
    req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      #1;
      check("grant_all", 64'(req_ready), 64'(1) << (c % 4));
      if (c >= 2) check("rate_all", 64'(out_valid), 64'd1);
      cycle();
    end
    req_valid = 4'b1101;
    for (int c = 0; c < 9; c++) begin
      #1;
      check("grant_skip1", 64'(req_ready), 64'(1) << pat[c % 3]);
      check("rate_skip1", 64'(out_valid), 64'd1);
      cycle();
    end

    // Backpressure: full rate, out_ready low for 5 cycles.
    req_valid = 4'hF;
    for (int c = 0; c < 2; c++) begin
      #1;
      cycle();
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      if (s == 0) begin
        snap_id = out_id;
        snap_i  = out_i;
        snap_q  = out_q;
      end else begin
        check("stall_ready", 64'(req_ready), 64'd0);
      end
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_id", 64'(out_id), 64'(snap_id));
      check("stall_i", out_i, snap_i);
      check("stall_q", out_q, snap_q);
      cycle();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("release_ready", 64'($countones(req_ready)), 64'd1);
      cycle();
    end
    req_valid = '0;
    drain();

    // Single channel 2: a=(3,4), b=(5,-2).
    ai[2] = 3; aq[2] = 4; bi[2] = 5; bq[2] = -2;
    drive_data();
    req_valid = 4'b0100;
    #1;
    check("single_ready", 64'(req_ready), 64'b0100);
    cycle();
    req_valid = '0;
    #1;
    check("single_lat1", 64'(out_valid), 64'd0);
    cycle();
    #1;
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_id", 64'(out_id), 64'd2);
    check("single_i", out_i, 64'sd23);
    check("single_q", out_q, 64'sd14);
    cycle();

    // Extreme operands on channels 0 and 1.
    ai[0] = -32768; aq[0] = -32768; bi[0] = -32768; bq[0] = 32767;
    ai[1] = -32768; aq[1] = 0;      bi[1] = -32768; bq[1] = 0;
    drive_data();
    req_valid = 4'b0001;
    #1;
    check("ext0_ready", 64'(req_ready), 64'b0001);
    cycle();
    req_valid = 4'b0010;
    #1;
    check("ext1_ready", 64'(req_ready), 64'b0010);
    cycle();
    req_valid = '0;
    #1;
    check("ext0_id", 64'(out_id), 64'd0);
    check("ext0_i", out_i, 64'sd2147450880);
    check("ext0_q", out_q, 64'sd32768);
    cycle();
    #1;
    check("ext1_id", 64'(out_id), 64'd1);
    check("ext1_i", out_i, 64'sd1073741824);
    check("ext1_q", out_q, 64'sd0);
    cycle();

    // Stage 1 still loads while stage 2 is blocked.
    req_valid = 4'b1000;
    #1;
    cycle();
    req_valid = '0;
    #1;
    cycle();
    out_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("s1_fill_ready", 64'(req_ready), 64'b0001);
    check("s1_fill_out", 64'(out_valid), 64'd1);
    cycle();
    req_valid = 4'b0100;
    #1;
    check("s1_full_ready", 64'(req_ready), 64'd0);
    check("s1_full_hold_id", 64'(out_id), 64'd3);
    cycle();
    out_ready = 1'b1;
    #1;
    check("s1_release_ready", 64'(req_ready), 64'b0100);
    cycle();
    req_valid = '0;
    drain();

    // Reset mid-stream with both stages full and ptr left at 3.
    req_valid = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      cycle();
    end
    req_valid = 4'b0100;
    #1;
    cycle();
    rst       = 1'b1;
    req_valid = 4'b1010;
    #1;
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_full", 64'(out_valid), 64'd1);
    cycle();
    rst = 1'b0;
    sb.delete();
    n_out = 0;
    #1;
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_grant", 64'(req_ready), 64'b0010);
    cycle();
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      cycle();
    end
    req_valid = '0;
    drain();

`ifdef CMULT_SHARE_STAT_EN
    check("stat_count", 64'(stat_txn_cnt), 64'(n_out));
    force dut.stat_txn_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stat_txn_cnt;
    req_valid = 4'b0001;
    #1;
    cycle();
    req_valid = '0;
    drain();
    check("stat_wrap", 64'(stat_txn_cnt), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
